// File: rtl/period_meter.sv
// Period meter: counts clk cycles between consecutive rising edges of an asynchronous strobe
// and hands each result out over valid/ready, with one-cycle timeout and overrun pulses.
module period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic [WIDTH-1:0] meas,
  output logic             meas_valid,
  output logic             timeout,
  output logic             overrun
);

  localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] meas_q, meas_d;
  logic             meas_valid_q, meas_valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             res_vld;

  // s1/s2 resynchronise sig_in; s3 is the history flop for edge detection
  assign rise = s2_q & ~s3_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      cnt_q        <= '0;
      meas_q       <= '0;
      meas_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= sig_in;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      cnt_q        <= cnt_d;
      meas_q       <= meas_d;
      meas_valid_q <= meas_valid_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state and cycle counter; a rise on the TIMEOUT cycle still counts as an edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = COUNT;
          cnt_d   = ONE_W;
        end else begin
          cnt_d = '0;
        end
      end
      COUNT: begin
        if (rise) begin
          cnt_d = ONE_W;
        end else if (cnt_q == TIMEOUT_W) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE_W;
        end
      end
    endcase
  end

  // Result handoff and event pulses
  always_comb begin
    res_vld      = (state_q == COUNT) && rise;
    timeout_d    = (state_q == COUNT) && !rise && (cnt_q == TIMEOUT_W);
    meas_d       = meas_q;
    meas_valid_d = meas_valid_q;
    overrun_d    = 1'b0;
    if (res_vld) begin
      if (!meas_valid_q || meas_ready) begin
        meas_d       = cnt_q;
        meas_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (meas_valid_q && meas_ready) begin
      meas_valid_d = 1'b0;
    end
  end

  assign meas       = meas_q;
  assign meas_valid = meas_valid_q;
  assign timeout    = timeout_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: timestamp-based reference model checked every cycle, a table of
// periodic-edge vectors, hand-written corner sequences and a randomized phase.
module tb_period_meter;

  localparam int unsigned W = 16;
  localparam int unsigned T = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig_in = 1'b0;
  logic         meas_ready = 1'b1;
  logic [W-1:0] meas;
  logic         meas_valid;
  logic         timeout;
  logic         overrun;

  period_meter #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .sig_in     (sig_in),
    .meas_ready (meas_ready),
    .meas       (meas),
    .meas_valid (meas_valid),
    .timeout    (timeout),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: sampled input history, timestamp of the reference edge, pending result
  int       cyc = 0;
  bit [3:0] hist = '0;
  bit       armed = 1'b0;
  int       last_t = 0;
  bit       m_valid = 1'b0;
  bit       m_to = 1'b0;
  bit       m_ov = 1'b0;
  int       m_meas = 0;

  logic [W-1:0] obs_q[$];
  int           to_cnt = 0;
  int           ov_cnt = 0;

  always @(posedge clk) begin
    bit rise_m;
    bit res_v;
    int res;
    int t;
    cyc++;
    if (rst) begin
      hist    = '0;
      armed   = 1'b0;
      m_valid = 1'b0;
      m_meas  = 0;
      m_to    = 1'b0;
      m_ov    = 1'b0;
    end else begin
      hist   = {hist[2:0], sig_in};
      t      = cyc - 2;
      rise_m = hist[2] && !hist[3];
      res_v  = 1'b0;
      res    = 0;
      m_to   = 1'b0;
      m_ov   = 1'b0;
      if (rise_m) begin
        if (armed) begin
          res_v = 1'b1;
          res   = t - last_t;
        end
        last_t = t;
        armed  = 1'b1;
      end else if (armed && (t - last_t) == int'(T)) begin
        m_to  = 1'b1;
        armed = 1'b0;
      end
      if (res_v) begin
        if (!m_valid || meas_ready) begin
          m_meas  = res;
          m_valid = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_valid && meas_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    n_tests++;
    if (meas !== W'(m_meas) || meas_valid !== m_valid || timeout !== m_to || overrun !== m_ov) begin
      n_fail++;
      $display("FAIL scoreboard cyc=%0d got meas=%0d v=%b to=%b ov=%b expected meas=%0d v=%b to=%b ov=%b",
               cyc, meas, meas_valid, timeout, overrun, m_meas, m_valid, m_to, m_ov);
    end
    if (meas_valid === 1'b1) obs_q.push_back(meas);
    if (timeout === 1'b1) to_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    to_cnt = 0;
    ov_cnt = 0;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    sig_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  // One sampled-high cycle followed by p-1 low cycles: rising edges p cycles apart
  task automatic pulse(input int p);
    sig_in = 1'b1;
    tick(1);
    sig_in = 1'b0;
    tick(p - 1);
  endtask

  typedef struct {
    int period;
    int exp_res;
    int exp_meas;
    int exp_to;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int k;
    int mode;
    int len;
    int pp;

    vecs[0] = '{period: 10, exp_res: 4, exp_meas: 10, exp_to: 1};
    vecs[1] = '{period: 2,  exp_res: 4, exp_meas: 2,  exp_to: 1};
    vecs[2] = '{period: 3,  exp_res: 4, exp_meas: 3,  exp_to: 1};
    vecs[3] = '{period: 19, exp_res: 4, exp_meas: 19, exp_to: 1};
    vecs[4] = '{period: 20, exp_res: 4, exp_meas: 20, exp_to: 1};
    vecs[5] = '{period: 21, exp_res: 0, exp_meas: 0,  exp_to: 5};

    // Reset state
    tick(2);
    check("reset_meas", int'(meas), 0);
    check("reset_valid", int'(meas_valid), 0);
    check("reset_pulses", int'({timeout, overrun}), 0);
    rst = 1'b0;
    tick(2);

    // Table: five edges at a fixed period with the consumer always ready
    foreach (vecs[i]) begin
      meas_ready = 1'b1;
      do_reset();
      clear_obs();
      repeat (5) pulse(vecs[i].period);
      tick(30);
      check($sformatf("tbl%0d_results", i), obs_q.size(), vecs[i].exp_res);
      foreach (obs_q[j]) check($sformatf("tbl%0d_meas%0d", i, j), int'(obs_q[j]), vecs[i].exp_meas);
      check($sformatf("tbl%0d_timeouts", i), to_cnt, vecs[i].exp_to);
      check($sformatf("tbl%0d_overruns", i), ov_cnt, 0);
    end

    // Stalled consumer: first result held, later ones dropped with overrun
    do_reset();
    meas_ready = 1'b0;
    clear_obs();
    repeat (3) pulse(8);
    sig_in = 1'b1; tick(1); sig_in = 1'b0; tick(6);
    check("stall_meas", int'(meas), 8);
    check("stall_valid", int'(meas_valid), 1);
    check("stall_overruns", ov_cnt, 2);
    meas_ready = 1'b1;
    tick(1);
    check("stall_drain_valid", int'(meas_valid), 0);
    check("stall_drain_meas", int'(meas), 8);
    sig_in = 1'b1; tick(1); sig_in = 1'b0; tick(2);
    check("stall_reload_valid", int'(meas_valid), 1);
    check("stall_reload_meas", int'(meas), 8);

    // Reset mid-measurement with a pending result
    do_reset();
    meas_ready = 1'b0;
    pulse(10);
    pulse(10);
    sig_in = 1'b1; tick(1); sig_in = 1'b0; tick(3);
    check("midrst_pending", int'(meas_valid), 1);
    rst = 1'b1;
    tick(1);
    check("midrst_outputs", int'({meas, meas_valid, timeout, overrun}), 0);
    tick(1);
    check("midrst_outputs2", int'({meas, meas_valid, timeout, overrun}), 0);
    rst = 1'b0;
    meas_ready = 1'b1;
    clear_obs();
    tick(3);
    pulse(10);
    pulse(10);
    tick(5);
    check("midrst_results", obs_q.size(), 1);
    if (obs_q.size() > 0) check("midrst_meas", int'(obs_q[0]), 10);

    // Accept and new result in the same cycle
    do_reset();
    meas_ready = 1'b0;
    clear_obs();
    pulse(5);
    sig_in = 1'b1; tick(1); sig_in = 1'b0; tick(6);
    check("swap_meas_before", int'(meas), 5);
    check("swap_valid_before", int'(meas_valid), 1);
    sig_in = 1'b1; tick(1); sig_in = 1'b0; tick(1);
    check("swap_valid_mid", int'(meas_valid), 1);
    meas_ready = 1'b1;
    tick(1);
    check("swap_meas_after", int'(meas), 7);
    check("swap_valid_after", int'(meas_valid), 1);
    check("swap_overrun", int'(overrun), 0);
    check("swap_overrun_cnt", ov_cnt, 0);

    // sig_in already high when reset releases
    meas_ready = 1'b1;
    rst = 1'b1;
    sig_in = 1'b1;
    tick(2);
    rst = 1'b0;
    clear_obs();
    tick(1);
    sig_in = 1'b0; tick(5);
    sig_in = 1'b1; tick(1);
    sig_in = 1'b0; tick(4);
    check("relhigh_results", obs_q.size(), 1);
    if (obs_q.size() > 0) check("relhigh_meas", int'(obs_q[0]), 6);

    // Timeout latency after a lone edge, then re-arm
    do_reset();
    clear_obs();
    sig_in = 1'b1; tick(1); sig_in = 1'b0;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      if (timeout === 1'b1 && k < 0) k = i;
    end
    check("timeout_latency", k, int'(T) + 2);
    check("timeout_count", to_cnt, 1);
    check("timeout_no_result", obs_q.size(), 0);
    pulse(5);
    pulse(5);
    tick(3);
    check("rearm_results", obs_q.size(), 1);
    if (obs_q.size() > 0) check("rearm_meas", int'(obs_q[0]), 5);

    // Randomized segments checked by the scoreboard
    do_reset();
    for (int s = 0; s < 40; s++) begin
      mode = int'($urandom_range(0, 2));
      len  = int'($urandom_range(20, 120));
      pp   = int'($urandom_range(2, 24));
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       sig_in = ($urandom_range(0, 5) == 0);
          1:       sig_in = ((i % pp) == 0);
          default: sig_in = 1'b0;
        endcase
        meas_ready = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 299) == 0);
        tick(1);
      end
    end
    rst = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
